// File: rtl/mem_access_unit_if.sv
// Request, data-cache and writeback/exception signals of the MEM-stage memory access unit.
// Port summary: req_* from the MEM stage, cache_* to/from the data cache, resp_*/exc_* to writeback.
// slave = the access unit's view, master = the environment's view (pipeline + cache).
interface mem_access_unit_if;
    // MEM stage request
    logic        req_valid_i;
    logic        req_is_store_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  req_rd_i;
    logic        req_ready_o;
    logic        stall_o;
    // data cache port
    logic [31:0] cache_addr_o;
    logic [31:0] cache_wdata_o;
    logic [3:0]  cache_sel_o;
    logic [31:0] cache_rdata_i;
    logic        cache_busy_i;
    // writeback
    logic        resp_valid_o;
    logic        resp_we_o;
    logic [31:0] resp_rdata_o;
    logic [4:0]  resp_rd_o;
    logic        exc_valid_o;
    logic [3:0]  exc_cause_o;
    logic [31:0] exc_addr_o;

    modport slave (
        input  req_valid_i, req_is_store_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
        input  cache_rdata_i, cache_busy_i,
        output req_ready_o, stall_o,
        output cache_addr_o, cache_wdata_o, cache_sel_o,
        output resp_valid_o, resp_we_o, resp_rdata_o, resp_rd_o,
        output exc_valid_o, exc_cause_o, exc_addr_o
    );

    modport master (
        output req_valid_i, req_is_store_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
        output cache_rdata_i, cache_busy_i,
        input  req_ready_o, stall_o,
        input  cache_addr_o, cache_wdata_o, cache_sel_o,
        input  resp_valid_o, resp_we_o, resp_rdata_o, resp_rd_o,
        input  exc_valid_o, exc_cause_o, exc_addr_o
    );
endinterface

// File: rtl/mem_access_unit.sv
// Purpose: RV32 load/store initiator for the data cache; legality/alignment check, busy watchdog, writeback result.
// Latency: legal op 2 cycles + 1 per busy cycle (IDLE->ACCESS->DONE); illegal/misaligned op 1 cycle.
// Backpressure: stall_o holds the MEM stage while in flight; cache_busy_i stretches WAIT, bounded by TIMEOUT_CYCLES (0 = unbounded).
// Ports: clk_i, rst_ni (async active-low), bus (mem_access_unit_if.slave).
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    mem_access_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    // A zero timeout still needs a 1-bit counter so the logic stays well formed.
    localparam int unsigned    CNT_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam bit             WDOG_ON = (TIMEOUT_CYCLES != 0);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_store_q, is_store_d;
    logic [31:0]       cache_addr_q, cache_addr_d;
    logic [31:0]       cache_wdata_q, cache_wdata_d;
    logic [3:0]        cache_sel_q, cache_sel_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_we_q, resp_we_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic [4:0]        resp_rd_q, resp_rd_d;
    logic              exc_valid_q, exc_valid_d;
    logic [3:0]        exc_cause_q, exc_cause_d;
    logic [31:0]       exc_addr_q, exc_addr_d;

    // Request decode: cache select, funct3 legality and natural alignment.
    logic [3:0] req_sel;
    logic       req_legal;
    logic       req_misal;

    always_comb begin
        req_sel   = 4'b0000;
        req_legal = 1'b1;
        req_misal = 1'b0;
        if (bus.req_is_store_i) begin
            unique case (bus.req_funct3_i)
                3'b000:  req_sel = 4'b1011;
                3'b001:  req_sel = 4'b1110;
                3'b010:  req_sel = 4'b1111;
                default: req_legal = 1'b0;
            endcase
        end else begin
            unique case (bus.req_funct3_i)
                3'b000:  req_sel = 4'b1000;
                3'b001:  req_sel = 4'b1001;
                3'b010:  req_sel = 4'b1010;
                3'b100:  req_sel = 4'b1100;
                3'b101:  req_sel = 4'b1101;
                default: req_legal = 1'b0;
            endcase
        end
        // funct3[1:0] gives the access size for every legal encoding.
        unique case (bus.req_funct3_i[1:0])
            2'b01:   req_misal = bus.req_addr_i[0];
            2'b10:   req_misal = (bus.req_addr_i[1:0] != 2'b00);
            default: req_misal = 1'b0;
        endcase
    end

    logic [CNT_W-1:0] cnt_inc;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        is_store_d    = is_store_q;
        cache_addr_d  = cache_addr_q;
        cache_wdata_d = cache_wdata_q;
        cache_sel_d   = cache_sel_q;
        resp_valid_d  = 1'b0;
        resp_we_d     = 1'b0;
        resp_rdata_d  = resp_rdata_q;
        resp_rd_d     = resp_rd_q;
        exc_valid_d   = 1'b0;
        exc_cause_d   = exc_cause_q;
        exc_addr_d    = exc_addr_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    is_store_d    = bus.req_is_store_i;
                    cache_addr_d  = bus.req_addr_i;
                    cache_wdata_d = bus.req_wdata_i;
                    resp_rd_d     = bus.req_rd_i;
                    if (!req_legal) begin
                        exc_valid_d = 1'b1;
                        exc_cause_d = 4'd2;
                        exc_addr_d  = 32'h0;
                        state_d     = S_DONE;
                    end else if (req_misal) begin
                        exc_valid_d = 1'b1;
                        exc_cause_d = bus.req_is_store_i ? 4'd6 : 4'd4;
                        exc_addr_d  = bus.req_addr_i;
                        state_d     = S_DONE;
                    end else begin
                        cache_sel_d = req_sel;
                        state_d     = S_ACCESS;
                    end
                end
            end
            S_ACCESS, S_WAIT: begin
                if (!bus.cache_busy_i) begin
                    cache_sel_d  = 4'b0000;
                    resp_valid_d = 1'b1;
                    resp_we_d    = !is_store_q && (resp_rd_q != 5'd0);
                    if (!is_store_q) begin
                        resp_rdata_d = bus.cache_rdata_i;
                    end
                    state_d = S_DONE;
                end else if (state_q == S_ACCESS) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_inc;
                    if (WDOG_ON && (cnt_inc == CNT_LIM)) begin
                        cache_sel_d = 4'b0000;
                        exc_valid_d = 1'b1;
                        exc_cause_d = is_store_q ? 4'd7 : 4'd5;
                        exc_addr_d  = cache_addr_q;
                        state_d     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // The request still visible here is the one just retired.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            is_store_q    <= 1'b0;
            cache_addr_q  <= 32'h0;
            cache_wdata_q <= 32'h0;
            cache_sel_q   <= 4'b0000;
            resp_valid_q  <= 1'b0;
            resp_we_q     <= 1'b0;
            resp_rdata_q  <= 32'h0;
            resp_rd_q     <= 5'd0;
            exc_valid_q   <= 1'b0;
            exc_cause_q   <= 4'd0;
            exc_addr_q    <= 32'h0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            is_store_q    <= is_store_d;
            cache_addr_q  <= cache_addr_d;
            cache_wdata_q <= cache_wdata_d;
            cache_sel_q   <= cache_sel_d;
            resp_valid_q  <= resp_valid_d;
            resp_we_q     <= resp_we_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_rd_q     <= resp_rd_d;
            exc_valid_q   <= exc_valid_d;
            exc_cause_q   <= exc_cause_d;
            exc_addr_q    <= exc_addr_d;
        end
    end

    assign bus.req_ready_o   = (state_q == S_IDLE);
    assign bus.stall_o       = ((state_q == S_IDLE) && bus.req_valid_i) ||
                               (state_q == S_ACCESS) || (state_q == S_WAIT);
    assign bus.cache_addr_o  = cache_addr_q;
    assign bus.cache_wdata_o = cache_wdata_q;
    assign bus.cache_sel_o   = cache_sel_q;
    assign bus.resp_valid_o  = resp_valid_q;
    assign bus.resp_we_o     = resp_we_q;
    assign bus.resp_rdata_o  = resp_rdata_q;
    assign bus.resp_rd_o     = resp_rd_q;
    assign bus.exc_valid_o   = exc_valid_q;
    assign bus.exc_cause_o   = exc_cause_q;
    assign bus.exc_addr_o    = exc_addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: two instances (watchdog 4 and watchdog disabled) share one stimulus.
// Each op is checked cycle by cycle against a transaction-level reference model.
// Directed cases first, then randomized ops on both instances.
module tb_mem_access_unit;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    logic rst_ni;

    logic        req_valid, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, cache_rdata;
    logic [4:0]  req_rd;
    logic        cache_busy;

    mem_access_unit_if ifa();
    mem_access_unit_if ifb();

    assign ifa.req_valid_i    = req_valid;
    assign ifa.req_is_store_i = req_is_store;
    assign ifa.req_funct3_i   = req_funct3;
    assign ifa.req_addr_i     = req_addr;
    assign ifa.req_wdata_i    = req_wdata;
    assign ifa.req_rd_i       = req_rd;
    assign ifa.cache_rdata_i  = cache_rdata;
    assign ifa.cache_busy_i   = cache_busy;
    assign ifb.req_valid_i    = req_valid;
    assign ifb.req_is_store_i = req_is_store;
    assign ifb.req_funct3_i   = req_funct3;
    assign ifb.req_addr_i     = req_addr;
    assign ifb.req_wdata_i    = req_wdata;
    assign ifb.req_rd_i       = req_rd;
    assign ifb.cache_rdata_i  = cache_rdata;
    assign ifb.cache_busy_i   = cache_busy;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut_a (.clk_i(clk_i), .rst_ni(rst_ni), .bus(ifa));
    mem_access_unit #(.TIMEOUT_CYCLES(0)) dut_b (.clk_i(clk_i), .rst_ni(rst_ni), .bus(ifb));

    // Output view of the instance under check.
    int dut_sel = 0;
    logic        o_ready, o_stall, o_rv, o_we, o_ev;
    logic [31:0] o_caddr, o_cwdata, o_rdata, o_eaddr;
    logic [3:0]  o_sel, o_cause;
    logic [4:0]  o_rd;
    assign o_ready  = dut_sel ? ifb.req_ready_o   : ifa.req_ready_o;
    assign o_stall  = dut_sel ? ifb.stall_o       : ifa.stall_o;
    assign o_caddr  = dut_sel ? ifb.cache_addr_o  : ifa.cache_addr_o;
    assign o_cwdata = dut_sel ? ifb.cache_wdata_o : ifa.cache_wdata_o;
    assign o_sel    = dut_sel ? ifb.cache_sel_o   : ifa.cache_sel_o;
    assign o_rv     = dut_sel ? ifb.resp_valid_o  : ifa.resp_valid_o;
    assign o_we     = dut_sel ? ifb.resp_we_o     : ifa.resp_we_o;
    assign o_rdata  = dut_sel ? ifb.resp_rdata_o  : ifa.resp_rdata_o;
    assign o_rd     = dut_sel ? ifb.resp_rd_o     : ifa.resp_rd_o;
    assign o_ev     = dut_sel ? ifb.exc_valid_o   : ifa.exc_valid_o;
    assign o_cause  = dut_sel ? ifb.exc_cause_o   : ifa.exc_cause_o;
    assign o_eaddr  = dut_sel ? ifb.exc_addr_o    : ifa.exc_addr_o;

    int checks   = 0;
    int failures = 0;
    int opn      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Transaction-level reference: legality table, size-based alignment,
    // and completion latency from the busy length and watchdog limit.
    function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                  input int b, input int t,
                                  output bit is_exc, output logic [3:0] cause,
                                  output logic [31:0] eaddr, output logic [3:0] sel, output int lat);
        logic [3:0] ld_tab [8];
        logic [3:0] st_tab [8];
        int size;
        ld_tab = '{4'b1000, 4'b1001, 4'b1010, 4'b0000, 4'b1100, 4'b1101, 4'b0000, 4'b0000};
        st_tab = '{4'b1011, 4'b1110, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        sel    = st ? st_tab[f3] : ld_tab[f3];
        size   = 1 << f3[1:0];
        is_exc = 1'b1;
        eaddr  = a;
        lat    = 1;
        if (sel == 4'b0000) begin
            cause = 4'd2;
            eaddr = 32'h0;
        end else if ((a % size) != 0) begin
            cause = st ? 4'd6 : 4'd4;
        end else if (t != 0 && b > t) begin
            cause = st ? 4'd7 : 4'd5;
            lat   = t + 2;
        end else begin
            is_exc = 1'b0;
            cause  = 4'd0;
            lat    = b + 2;
        end
    endfunction

    // Called just after a rising edge with the unit idle; consumes the op plus one idle cycle.
    task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] rdat, input int b);
        bit          e;
        logic [3:0]  cause, sel;
        logic [31:0] eaddr;
        int          lat;
        string       p;
        model(st, f3, a, b, (dut_sel != 0) ? 0 : 4, e, cause, eaddr, sel, lat);
        opn++;
        p = $sformatf("op%0d", opn);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
        req_addr = a; req_wdata = wd; req_rd = rd;
        cache_busy = 1'b0; cache_rdata = ~rdat;
        @(negedge clk_i);
        chk({p, "_issue_ready"}, 32'(o_ready), 32'd1);
        chk({p, "_issue_stall"}, 32'(o_stall), 32'd1);
        chk({p, "_issue_sel"}, 32'(o_sel), 32'd0);
        for (int k = 1; k <= lat; k++) begin
            next_cycle();
            cache_busy  = (k <= b);
            cache_rdata = (k <= b) ? ~rdat : rdat;
            @(negedge clk_i);
            if (k < lat) begin
                chk($sformatf("%s_c%0d_stall", p, k), 32'(o_stall), 32'd1);
                chk($sformatf("%s_c%0d_ready", p, k), 32'(o_ready), 32'd0);
                chk($sformatf("%s_c%0d_sel", p, k), 32'(o_sel), 32'(sel));
                chk($sformatf("%s_c%0d_caddr", p, k), o_caddr, a);
                chk($sformatf("%s_c%0d_cwdata", p, k), o_cwdata, wd);
                chk($sformatf("%s_c%0d_pulses", p, k), {o_rv, o_ev}, 32'd0);
            end else begin
                chk({p, "_done_stall"}, 32'(o_stall), 32'd0);
                chk({p, "_done_ready"}, 32'(o_ready), 32'd0);
                chk({p, "_done_sel"}, 32'(o_sel), 32'd0);
                chk({p, "_done_rv"}, 32'(o_rv), 32'(!e));
                chk({p, "_done_ev"}, 32'(o_ev), 32'(e));
                if (e) begin
                    chk({p, "_done_cause"}, 32'(o_cause), 32'(cause));
                    chk({p, "_done_eaddr"}, o_eaddr, eaddr);
                end else begin
                    chk({p, "_done_we"}, 32'(o_we), 32'(!st && rd != 5'd0));
                    chk({p, "_done_rd"}, 32'(o_rd), 32'(rd));
                    if (!st) chk({p, "_done_rdata"}, o_rdata, rdat);
                end
            end
        end
        next_cycle();
        req_valid = 1'b0; cache_busy = 1'b0;
        @(negedge clk_i);
        chk({p, "_after_ready"}, 32'(o_ready), 32'd1);
        chk({p, "_after_stall"}, 32'(o_stall), 32'd0);
        chk({p, "_after_pulses"}, {o_rv, o_ev}, 32'd0);
        next_cycle();
    endtask

    task automatic do_reset();
        next_cycle();
        rst_ni = 1'b0; req_valid = 1'b0; cache_busy = 1'b0;
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();
    endtask

    task automatic rand_op(input int bmax);
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a;
        st = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 3) != 0) f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
        a = $urandom;
        if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
        do_op(st, f3, a, $urandom, 5'($urandom_range(0, 31)), $urandom, int'($urandom_range(0, bmax)));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_ni = 1'b0;
        req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        cache_rdata = 32'h0; cache_busy = 1'b0;
        @(negedge clk_i);
        chk("rst_sel", 32'(o_sel), 32'd0);
        chk("rst_caddr", o_caddr, 32'h0);
        chk("rst_cwdata", o_cwdata, 32'h0);
        chk("rst_outs", {o_rv, o_we, o_ev, o_rd, o_cause}, 32'd0);
        chk("rst_rdata", o_rdata, 32'h0);
        chk("rst_eaddr", o_eaddr, 32'h0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_stall", 32'(o_stall), 32'd0);
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();

        // Directed cases on the watchdog-4 instance.
        do_op(1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0);   // LW
        do_op(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 5'd0, 32'h0, 3);   // SH busy 3
        do_op(1'b0, 3'b001, 32'h103, 32'h0, 5'd7, 32'h0, 0);          // LH misaligned
        do_op(1'b1, 3'b010, 32'h102, 32'h55, 5'd0, 32'h0, 0);         // SW misaligned
        do_op(1'b0, 3'b011, 32'h200, 32'h0, 5'd3, 32'h0, 0);          // illegal load
        do_op(1'b1, 3'b100, 32'h200, 32'h0, 5'd0, 32'h0, 0);          // illegal store
        do_op(1'b0, 3'b000, 32'h333, 32'h0, 5'd9, 32'h0, 20);         // LB watchdog
        do_op(1'b1, 3'b000, 32'h444, 32'hAB, 5'd0, 32'h0, 20);        // SB watchdog
        do_op(1'b0, 3'b010, 32'h80, 32'h0, 5'd0, 32'hCAFEF00D, 1);    // LW rd=0
        do_op(1'b0, 3'b101, 32'h82, 32'h0, 5'd31, 32'h0000FFFF, 4);   // LHU busy 4, no fault

        // Reset while waiting abandons the access.
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h40; req_rd = 5'd4; cache_busy = 1'b1;
        next_cycle();
        next_cycle();
        chk("rstwait_sel_before", 32'(o_sel), 32'b1010);
        #2;
        rst_ni = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rstwait_sel", 32'(o_sel), 32'd0);
        chk("rstwait_ready", 32'(o_ready), 32'd1);
        next_cycle();
        rst_ni = 1'b1;
        cache_busy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk($sformatf("rstwait_quiet%0d", k), {o_rv, o_ev, o_sel}, 32'd0);
            next_cycle();
        end
        do_op(1'b0, 3'b100, 32'h41, 32'h0, 5'd6, 32'h000000A5, 0);    // LBU

        for (int i = 0; i < 40; i++) rand_op(6);

        // Watchdog disabled: a long busy stretch completes normally.
        dut_sel = 1;
        do_reset();
        do_op(1'b0, 3'b000, 32'h51, 32'h0, 5'd2, 32'hFFFFFF80, 9);
        for (int i = 0; i < 12; i++) rand_op(9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage initiator for the RV32IM pipelined CPU's data cache port. It accepts one load/store per transaction from the MEM stage and checks funct3 legality and address alignment. It drives the cache's 4-bit read/write select encoding, waits out the cache busy flag under a watchdog, and returns the load result or an exception record to writeback. While a transaction is in flight it holds the pipeline with `stall_o`.

## Interface
- `TIMEOUT_CYCLES`, 255: WAIT-state cycles tolerated with `cache_busy_i` high before an access fault; 0 disables the watchdog.
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: MEM stage presents a memory op.
- `req_is_store_i` in 1: 1 = store, 0 = load.
- `req_funct3_i` in 3: RV32 funct3 of the op.
- `req_addr_i` in 32: effective byte address.
- `req_wdata_i` in 32: store data (rs2).
- `req_rd_i` in 5: load destination register.
- `req_ready_o` out 1: unit is in IDLE and samples the request this cycle.
- `stall_o` out 1: MEM stage must hold its instruction.
- `cache_addr_o` out 32: address to the data cache.
- `cache_wdata_o` out 32: write data to the data cache.
- `cache_sel_o` out 4: read/write select to the data cache.
- `cache_rdata_i` in 32: extended load data from the cache (combinational).
- `cache_busy_i` in 1: cache not finished with the current select.
- `resp_valid_o` out 1: one-cycle completion pulse.
- `resp_we_o` out 1: write `resp_rdata_o` to `resp_rd_o` (load with rd ≠ 0).
- `resp_rdata_o` out 32: registered load result.
- `resp_rd_o` out 5: destination register.
- `exc_valid_o` out 1: one-cycle exception pulse, mutually exclusive with `resp_valid_o`.
- `exc_cause_o` out 4: mcause code (2, 4, 5, 6 or 7).
- `exc_addr_o` out 32: mtval, the faulting address (0 for cause 2).

## Operation
- Select encoding, with bit 3 meaning access active:
  - Loads: LB=1000, LH=1001, LW=1010, LBU=1100, LHU=1101.
  - Stores: SB=1011, SH=1110, SW=1111.
  - Idle: 0000.
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: anything other than 000, 001, 010.
  - Result: cause 2.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠00. Result: cause 4 for loads, cause 6 for stores.
- State machine, four states:
  - **IDLE** (`req_ready_o`=1, `cache_sel_o`=0000):
    - On `req_valid_i`, latch addr, wdata, rd, is_store and funct3.
    - Illegal or misaligned: load the exception registers and go to DONE with no cache access.
    - Otherwise go to ACCESS.
  - **ACCESS**:
    - Drive `cache_addr_o`, `cache_wdata_o` (full 32 bits; the cache uses the low bytes) and `cache_sel_o` from the latched request.
    - At the clock edge, if `cache_busy_i`=0: capture `cache_rdata_i` (loads) and go to DONE.
    - Otherwise clear the watchdog counter and go to WAIT.
  - **WAIT**:
    - Keep driving the cache. The counter increments every cycle `cache_busy_i`=1.
    - `cache_busy_i`=0: capture the data and go to DONE.
    - Counter reaches TIMEOUT_CYCLES (nonzero) with busy still high: raise an access fault (cause 5 for loads, 7 for stores), `exc_addr_o` = address, go to DONE.
  - **DONE**:
    - `cache_sel_o`=0000. Exactly one of `resp_valid_o` / `exc_valid_o` is high.
    - `req_ready_o`=0: the request visible this cycle is the one just completed and is ignored.
    - Next state: IDLE.
- `stall_o` = (IDLE and `req_valid_i`) or ACCESS or WAIT. It is low in DONE, so the pipeline advances on the completion cycle.
- Stores complete with `resp_valid_o`=1 and `resp_we_o`=0. A load with rd=0 performs the access, but `resp_we_o`=0.
- Watchdog counter width: clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.

## Timing
- Legal request sampled in IDLE at cycle N:
  - ACCESS at N+1, DONE at N+2 when busy is low at N+1.
  - `stall_o` high in N and N+1.
  - Each busy cycle adds one cycle.
- Exception request at N: DONE at N+1 with `exc_valid_o`; `stall_o` high in N only.
- Watchdog: DONE at N+2+TIMEOUT_CYCLES.
- Registered outputs: `cache_*`, `resp_*`, `exc_*`. Combinational outputs: `req_ready_o`, `stall_o`.
- Reset values (immediate on `rst_ni` low): state IDLE, `cache_sel_o`=0000, `cache_addr_o`=0, `cache_wdata_o`=0, `resp_valid_o`=0, `resp_we_o`=0, `resp_rdata_o`=0, `resp_rd_o`=0, `exc_valid_o`=0, `exc_cause_o`=0, `exc_addr_o`=0, counter 0.
- Reset asserted mid-transaction abandons it. No response or exception is ever emitted for it, and `cache_sel_o` drops to 0000 asynchronously.
- Back-to-back ops: minimum issue interval is 3 cycles (IDLE, ACCESS, DONE).

## Test plan
- LW, addr 0x100, cache returns 0xDEADBEEF, busy 0 → `cache_sel_o`=1010 at N+1; at N+2 `resp_valid_o`=1, `resp_we_o`=1, `resp_rdata_o`=0xDEADBEEF; `stall_o` high for exactly 2 cycles.
- SH, addr 0x202, wdata 0x1234ABCD, busy high for 3 cycles → `cache_sel_o`=1110 held 4 cycles; DONE at N+5 with `resp_we_o`=0.
- LH at 0x103 → no cache access (`cache_sel_o` stays 0000); `exc_valid_o` at N+1, cause 4, `exc_addr_o`=0x103. Repeat with SW at 0x102 → cause 6.
- Load, funct3=011 → cause 2, `exc_addr_o`=0. Store, funct3=100 → cause 2.
- TIMEOUT_CYCLES=4, LB with busy stuck high → cause 5, `exc_addr_o` = address, at N+6. Repeat with TIMEOUT_CYCLES=0 → waits indefinitely; completes when busy drops.
- `rst_ni` pulsed low while in WAIT → `cache_sel_o`=0000 immediately; no pulse on `resp_valid_o` or `exc_valid_o`; next LBU completes normally. Separately, LW to rd=0 → `resp_valid_o`=1, `resp_we_o`=0.
